neuron_grid_sequencer: RTL and testbench
========================================

// Module: neuron_grid_sequencer
// PURPOSE
//  Parametrised successor to the single-core neuron-grid controller. Sequences one SNN core per tick:
//  for every neuron, walks every axon (process_spike), then updates potential. Owns neuron/axon counters
//  internally (no external done_* inputs) and queues ticks arriving mid-frame instead of only flagging error.
//  Sits between the tick source and the core datapath (scheduler SRAM, synapse RAM, neuron unit).
// PARAMETERS
//  NUM_NEURONS  256  neurons per core, >=1
//  NUM_AXONS    256  axons per core, >=1
//  MAX_PENDING  3    ticks bufferable while busy, >=1
//  N_W  $clog2(NUM_NEURONS)>0 ? .. : 1   neuron index width (derived localparam)
//  A_W  $clog2(NUM_AXONS)>0 ? .. : 1     axon index width (derived localparam)
// PORTS
//  clk               in   1    clock, all logic on posedge
//  reset             in   1    synchronous, active-high
//  tick              in   1    frame start pulse, one cycle
//  neuron_num        out  N_W  current neuron index
//  axon_num          out  A_W  current axon index
//  new_neuron        out  1    load params/potential of neuron_num
//  process_spike     out  1    integrate axon_num into neuron_num
//  apply_leak        out  1    leak step (0 unless NEURON_GRID_LEAK_EN)
//  update_potential  out  1    threshold/fire/write-back for neuron_num
//  scheduler_set     out  1    latch scheduler row for this frame
//  scheduler_clr     out  1    clear consumed scheduler row
//  done              out  1    one-cycle pulse, frame complete
//  busy              out  1    state != IDLE
//  wait_packets      out  1    IDLE and pending==0 (router may deliver packets)
//  pending_ticks     out  2+   queued tick count, width $clog2(MAX_PENDING+1)
//  tick_overflow     out  1    sticky: tick dropped; cleared only by reset
// BEHAVIOUR
//  Reset: state=IDLE, neuron_num=0, axon_num=0, pending_ticks=0, tick_overflow=0; all pulse outputs 0.
//  Pulse outputs decoded combinationally from state; counters/state registered.
//  FSM: IDLE -> GET_DATA -> INITIAL -> SPIKE_IN -> [LEAK] -> UPDATE -> END -> INITIAL | IDLE.
//   IDLE: go GET_DATA if tick or pending_ticks>0; else stay.
//   GET_DATA (1 cyc): scheduler_set=1, new_neuron=1, neuron_num<=0.
//   INITIAL (1 cyc): axon_num<=0, no strobes.
//   SPIKE_IN: process_spike=1 per cycle for axon_num=0..NUM_AXONS-1; axon_num++; last axon -> LEAK/UPDATE.
//   UPDATE (1 cyc): update_potential=1.
//   END: if neuron_num==NUM_NEURONS-1: done=1, scheduler_clr=1 -> IDLE; else neuron_num++, new_neuron=1 -> INITIAL.
//  Frame length NUM_NEURONS*(NUM_AXONS+3)+1 cycles after IDLE exit (+NUM_NEURONS with leak).
//  Tick queue: tick while busy -> pending+1; tick when pending==MAX_PENDING -> dropped, tick_overflow<=1.
//   IDLE start with pending>0 consumes one; simultaneous new tick adds one (net unchanged).
//   IDLE start by tick with pending==0 does not enqueue. Tick in END/done cycle counts as busy -> enqueued.
//  Back-to-back frames: IDLE occupies exactly one cycle between done and next GET_DATA when pending>0.
//  Counters never exceed NUM_*-1; no wrap. Reset mid-frame aborts immediately, no done/scheduler_clr.
// CONFIGURATION
//  NEURON_GRID_LEAK_EN defined: LEAK state (1 cyc) between SPIKE_IN and UPDATE, apply_leak=1 there.
//  Undefined: no LEAK state, apply_leak tied 0, frame length per formula without leak term.
// STRUCTURE
//  neuron_grid_pkg: state encoding localparams (IDLE..END, LEAK), width helper function for clog2 min 1.
//  Sub-module neuron_grid_tick_queue: saturating pending counter + sticky overflow (inputs tick, busy, consume).
//  Top holds FSM, neuron/axon counters, strobe decode.
// TESTING
//  NUM_NEURONS=2,NUM_AXONS=2, tick at cycle 0 -> GET_DATA at 1, process_spike axon 0,1 per neuron, done at cycle 11.
//  Same config, 3 ticks during frame (MAX_PENDING=3) -> pending_ticks=3, three further frames run back-to-back, no overflow.
//  4 ticks during frame with MAX_PENDING=3 -> pending stays 3, tick_overflow=1 until reset.
//  reset asserted mid SPIKE_IN -> next cycle IDLE, counters 0, done never pulses, wait_packets=1.
//  NEURON_GRID_LEAK_EN, 2x2 -> apply_leak once per neuron before update_potential, done at cycle 13.
//  NUM_NEURONS=1,NUM_AXONS=1 -> exactly one process_spike, one update_potential, done 5 cycles after tick.

Source files
------------

// File: rtl/neuron_grid_pkg.sv
// Shared state encoding and width helper for the neuron-grid sequencer.
// Optional leak step is enabled by NEURON_GRID_LEAK_EN in the top module.
package neuron_grid_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_GET_DATA = 3'd1;
  localparam logic [2:0] ST_INITIAL  = 3'd2;
  localparam logic [2:0] ST_SPIKE_IN = 3'd3;
  localparam logic [2:0] ST_UPDATE   = 3'd4;
  localparam logic [2:0] ST_END      = 3'd5;
  localparam logic [2:0] ST_LEAK     = 3'd6;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    GET_DATA = ST_GET_DATA,
    INITIAL  = ST_INITIAL,
    SPIKE_IN = ST_SPIKE_IN,
    UPDATE   = ST_UPDATE,
    END      = ST_END,
    LEAK     = ST_LEAK
  } state_e;

  // Index width that never collapses to zero for single-entry ranges.
  function automatic int clog2_min1(input int n);
    return ($clog2(n) > 0) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/neuron_grid_sequencer_if.sv
// Tick input and per-cycle control strobes between the sequencer (master)
// and the core datapath / tick source (slave).
interface neuron_grid_sequencer_if
  import neuron_grid_pkg::*;
#(
  parameter int NUM_NEURONS = 256,
  parameter int NUM_AXONS   = 256,
  parameter int MAX_PENDING = 3
);
  localparam int N_W = clog2_min1(NUM_NEURONS);
  localparam int A_W = clog2_min1(NUM_AXONS);
  localparam int P_W = clog2_min1(MAX_PENDING + 1);

  logic           tick;
  logic [N_W-1:0] neuron_num;
  logic [A_W-1:0] axon_num;
  logic           new_neuron;
  logic           process_spike;
  logic           apply_leak;
  logic           update_potential;
  logic           scheduler_set;
  logic           scheduler_clr;
  logic           done;
  logic           busy;
  logic           wait_packets;
  logic [P_W-1:0] pending_ticks;
  logic           tick_overflow;

  modport master (
    input  tick,
    output neuron_num, axon_num, new_neuron, process_spike, apply_leak,
           update_potential, scheduler_set, scheduler_clr, done, busy,
           wait_packets, pending_ticks, tick_overflow
  );

  modport slave (
    output tick,
    input  neuron_num, axon_num, new_neuron, process_spike, apply_leak,
           update_potential, scheduler_set, scheduler_clr, done, busy,
           wait_packets, pending_ticks, tick_overflow
  );

endinterface

// File: rtl/neuron_grid_tick_queue.sv
// Saturating count of ticks that arrived while a frame was running, plus a
// sticky flag recording any tick that had to be dropped.
module neuron_grid_tick_queue #(
  parameter int MAX_PENDING = 3,
  parameter int P_W         = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tick_i,
  input  logic           busy_i,
  input  logic           consume_i,
  output logic [P_W-1:0] pending_o,
  output logic           overflow_o
);

  localparam logic [P_W-1:0] MAX_P = P_W'(MAX_PENDING);

  logic [P_W-1:0] pending_q, pending_d;
  logic           overflow_q, overflow_d;
  logic           enq;

  // A tick that directly starts an idle frame is not queued; one that
  // coincides with draining the queue replaces the consumed entry.
  assign enq = tick_i && (busy_i || consume_i);

  always_comb begin
    pending_d  = pending_q;
    overflow_d = overflow_q;
    if (enq && !consume_i) begin
      if (pending_q == MAX_P) overflow_d = 1'b1;
      else                    pending_d  = pending_q + 1'b1;
    end else if (consume_i && !enq) begin
      pending_d = pending_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign pending_o  = pending_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/neuron_grid_sequencer.sv
// Per-tick sequencer for one SNN core: for each neuron, walk all axons then
// update the potential. Define NEURON_GRID_LEAK_EN to insert a LEAK step.
module neuron_grid_sequencer
  import neuron_grid_pkg::*;
#(
  parameter int NUM_NEURONS = 256,
  parameter int NUM_AXONS   = 256,
  parameter int MAX_PENDING = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  neuron_grid_sequencer_if.master  bus
);

  localparam int N_W = clog2_min1(NUM_NEURONS);
  localparam int A_W = clog2_min1(NUM_AXONS);
  localparam int P_W = clog2_min1(MAX_PENDING + 1);
  localparam logic [N_W-1:0] LAST_N = N_W'(NUM_NEURONS - 1);
  localparam logic [A_W-1:0] LAST_A = A_W'(NUM_AXONS - 1);

  state_e         state_q, state_d;
  logic [N_W-1:0] neuron_q, neuron_d;
  logic [A_W-1:0] axon_q, axon_d;
  logic [P_W-1:0] pending;
  logic           overflow;
  logic           is_idle, consume;
  logic           new_neuron, process_spike, apply_leak, update_potential;
  logic           scheduler_set, scheduler_clr, done;

  assign is_idle = (state_q == IDLE);
  assign consume = is_idle && (pending != '0);

  neuron_grid_tick_queue #(
    .MAX_PENDING (MAX_PENDING),
    .P_W         (P_W)
  ) u_tick_queue (
    .clk        (clk),
    .reset      (reset),
    .tick_i     (bus.tick),
    .busy_i     (!is_idle),
    .consume_i  (consume),
    .pending_o  (pending),
    .overflow_o (overflow)
  );

  always_comb begin
    state_d          = state_q;
    neuron_d         = neuron_q;
    axon_d           = axon_q;
    new_neuron       = 1'b0;
    process_spike    = 1'b0;
    apply_leak       = 1'b0;
    update_potential = 1'b0;
    scheduler_set    = 1'b0;
    scheduler_clr    = 1'b0;
    done             = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Clear on exit so the GET_DATA new_neuron strobe already sees index 0.
        if (bus.tick || (pending != '0)) begin
          state_d  = GET_DATA;
          neuron_d = '0;
        end
      end
      GET_DATA: begin
        scheduler_set = 1'b1;
        new_neuron    = 1'b1;
        neuron_d      = '0;
        state_d       = INITIAL;
      end
      INITIAL: begin
        axon_d  = '0;
        state_d = SPIKE_IN;
      end
      SPIKE_IN: begin
        process_spike = 1'b1;
        if (axon_q == LAST_A) begin
`ifdef NEURON_GRID_LEAK_EN
          state_d = LEAK;
`else
          state_d = UPDATE;
`endif
        end else begin
          axon_d = axon_q + 1'b1;
        end
      end
`ifdef NEURON_GRID_LEAK_EN
      LEAK: begin
        apply_leak = 1'b1;
        state_d    = UPDATE;
      end
`endif
      UPDATE: begin
        update_potential = 1'b1;
        state_d          = END;
      end
      END: begin
        if (neuron_q == LAST_N) begin
          done          = 1'b1;
          scheduler_clr = 1'b1;
          state_d       = IDLE;
        end else begin
          neuron_d   = neuron_q + 1'b1;
          new_neuron = 1'b1;
          state_d    = INITIAL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      neuron_q <= '0;
      axon_q   <= '0;
    end else begin
      state_q  <= state_d;
      neuron_q <= neuron_d;
      axon_q   <= axon_d;
    end
  end

  assign bus.neuron_num       = neuron_q;
  assign bus.axon_num         = axon_q;
  assign bus.new_neuron       = new_neuron;
  assign bus.process_spike    = process_spike;
  assign bus.apply_leak       = apply_leak;
  assign bus.update_potential = update_potential;
  assign bus.scheduler_set    = scheduler_set;
  assign bus.scheduler_clr    = scheduler_clr;
  assign bus.done             = done;
  assign bus.busy             = !is_idle;
  assign bus.wait_packets     = is_idle && (pending == '0);
  assign bus.pending_ticks    = pending;
  assign bus.tick_overflow    = overflow;

endmodule

// File: tb/tb_neuron_grid_sequencer.sv
// Scoreboard bench: a frame-offset reference model predicts every output each
// cycle; a negedge monitor pops predictions and compares against the DUT.
module tb_neuron_grid_sequencer;
  import neuron_grid_pkg::*;

  localparam int NN = 2;
  localparam int NA = 2;
  localparam int MP = 3;
`ifdef NEURON_GRID_LEAK_EN
  localparam int LK = 1;
`else
  localparam int LK = 0;
`endif
  localparam int L   = NA + 3 + LK;   // cycles per neuron: INITIAL, spikes, [leak], UPDATE, END
  localparam int F   = NN * L + 1;    // frame length including GET_DATA
  localparam int N_W = clog2_min1(NN);
  localparam int A_W = clog2_min1(NA);
  localparam int P_W = clog2_min1(MP + 1);

  typedef struct packed {
    logic [N_W-1:0] n;
    logic [A_W-1:0] a;
    logic           new_neuron;
    logic           process_spike;
    logic           apply_leak;
    logic           update_potential;
    logic           scheduler_set;
    logic           scheduler_clr;
    logic           done;
    logic           busy;
    logic           wait_packets;
    logic [P_W-1:0] pending;
    logic           overflow;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic reset1 = 1'b1;
  always #5 clk = ~clk;

  neuron_grid_sequencer_if #(.NUM_NEURONS(NN), .NUM_AXONS(NA), .MAX_PENDING(MP)) bus ();
  neuron_grid_sequencer #(.NUM_NEURONS(NN), .NUM_AXONS(NA), .MAX_PENDING(MP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  neuron_grid_sequencer_if #(.NUM_NEURONS(1), .NUM_AXONS(1), .MAX_PENDING(1)) bus1 ();
  neuron_grid_sequencer #(.NUM_NEURONS(1), .NUM_AXONS(1), .MAX_PENDING(1)) dut1 (
    .clk   (clk),
    .reset (reset1),
    .bus   (bus1)
  );

  int   checks = 0;
  int   errors = 0;
  obs_t exp_q[$];
  bit   one_done = 1'b0;

  // Reference model state: frame position and tick bookkeeping.
  bit m_in;
  int m_k, m_pend, m_n, m_a;
  bit m_ovf;

  task automatic step(input logic t, input logic r);
    obs_t e;
    int   j, n, rr;
    bit   consume, enq;
    e = '0;
    if (m_in) begin
      if (m_k == 1) begin
        e.scheduler_set = 1'b1;
        e.new_neuron    = 1'b1;
        m_n = 0;
      end else begin
        j  = m_k - 2;
        n  = j / L;
        rr = j % L;
        m_n = n;
        if (rr >= 1 && rr <= NA) begin
          e.process_spike = 1'b1;
          m_a = rr - 1;
        end else if (LK == 1 && rr == NA + 1) begin
          e.apply_leak = 1'b1;
        end else if (rr == L - 2) begin
          e.update_potential = 1'b1;
        end else if (rr == L - 1) begin
          if (n == NN - 1) begin
            e.done = 1'b1;
            e.scheduler_clr = 1'b1;
          end else begin
            e.new_neuron = 1'b1;
          end
        end
      end
    end
    e.n            = N_W'(m_n);
    e.a            = A_W'(m_a);
    e.busy         = m_in;
    e.wait_packets = !m_in && (m_pend == 0);
    e.pending      = P_W'(m_pend);
    e.overflow     = m_ovf;
    exp_q.push_back(e);

    bus.tick = t;
    reset    = r;

    if (r) begin
      m_in = 0; m_k = 0; m_pend = 0; m_ovf = 0; m_n = 0; m_a = 0;
    end else begin
      consume = !m_in && (m_pend > 0);
      enq     = t && (m_in || consume);
      if (enq && !consume) begin
        if (m_pend == MP) m_ovf = 1;
        else              m_pend++;
      end else if (consume && !enq) begin
        m_pend--;
      end
      if (m_in) begin
        if (m_k == F) m_in = 0;
        else          m_k++;
      end else if (t || consume) begin
        m_in = 1;
        m_k  = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    obs_t e, g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g.n                = bus.neuron_num;
      g.a                = bus.axon_num;
      g.new_neuron       = bus.new_neuron;
      g.process_spike    = bus.process_spike;
      g.apply_leak       = bus.apply_leak;
      g.update_potential = bus.update_potential;
      g.scheduler_set    = bus.scheduler_set;
      g.scheduler_clr    = bus.scheduler_clr;
      g.done             = bus.done;
      g.busy             = bus.busy;
      g.wait_packets     = bus.wait_packets;
      g.pending          = bus.pending_ticks;
      g.overflow         = bus.tick_overflow;
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got=%b expected=%b (n,a,new,spk,leak,upd,set,clr,done,busy,wait,pend,ovf)",
                 $time, g, e);
      end
    end
  end

  // Single-neuron, single-axon core: one spike, one update, done soon after tick.
  initial begin
    int spikes, upd, done_at;
    spikes = 0; upd = 0; done_at = -1;
    bus1.tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset1 = 1'b0;
    @(posedge clk); #1;
    bus1.tick = 1'b1;
    @(posedge clk); #1;
    bus1.tick = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (bus1.process_spike)    spikes++;
      if (bus1.update_potential) upd++;
      if (bus1.done) begin
        done_at = i;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (done_at != 1 * (1 + 3 + LK) + 1) begin
      errors++;
      $display("FAIL one_by_one_done_cycle got=%0d expected=%0d", done_at, 1 * (1 + 3 + LK) + 1);
    end
    checks++;
    if (spikes != 1) begin
      errors++;
      $display("FAIL one_by_one_spikes got=%0d expected=1", spikes);
    end
    checks++;
    if (upd != 1) begin
      errors++;
      $display("FAIL one_by_one_updates got=%0d expected=1", upd);
    end
    one_done = 1'b1;
  end

  initial begin
    m_in = 0; m_k = 0; m_pend = 0; m_ovf = 0; m_n = 0; m_a = 0;
    bus.tick = 1'b0;
    reset    = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single frame from a lone tick.
    step(1'b1, 1'b0);
    repeat (F + 4) step(1'b0, 1'b0);

    // Three ticks queued mid-frame, then back-to-back frames.
    step(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
    end
    repeat (4 * (F + 1) + 4) step(1'b0, 1'b0);

    // Four ticks mid-frame overflow the queue.
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    repeat (4) step(1'b1, 1'b0);
    repeat (4 * (F + 1) + 4) step(1'b0, 1'b0);

    // Reset during SPIKE_IN aborts the frame.
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (5) step(1'b0, 1'b0);

    // Random ticks with occasional resets.
    repeat (1500) step(logic'($urandom_range(0, 9) == 0), logic'($urandom_range(0, 199) == 0));
    repeat (5 * (F + 1)) step(1'b0, 1'b0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain left=%0d expected=0", exp_q.size());
    end
    for (int i = 0; i < 200 && !one_done; i++) @(posedge clk);
    if (!one_done) begin
      checks++;
      errors++;
      $display("FAIL one_by_one_timeout got=0 expected=1");
    end
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
